// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: sizing, the per-entry record
// and the bit positions inside the 3-bit system-instruction field.
package rob_pkg;

    localparam int ROB_DEPTH      = 8;
    localparam int TAGW           = $clog2(ROB_DEPTH);
    localparam int GPR_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;
    localparam int PC_WIDTH       = 32;

    // alloc_sys is {mret, ecall, ebreak}
    localparam int SYS_EBREAK = 0;
    localparam int SYS_ECALL  = 1;
    localparam int SYS_MRET   = 2;

    typedef struct packed {
        logic                      valid;
        logic                      done;
        logic                      dst_wen;
        logic [GPR_ADDR_WIDTH-1:0] dst;
        logic [DATA_WIDTH-1:0]     data;
        logic [PC_WIDTH-1:0]       pc;
        logic                      br_taken;
        logic [PC_WIDTH-1:0]       target;
        logic                      exp;
        logic [2:0]                sys;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit circular pointer used for the ROB head and tail.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   inc         advance by one entry at the edge
//   clr         return to zero at the edge (takes priority over inc)
//   ptr         TAGW index bits plus one wrap bit
module rob_ptr
    import rob_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [TAGW:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + (TAGW + 1)'(1);
        end
    end

endmodule

// File: rtl/rob_core.sv
// Reorder buffer: in-order allocation at dispatch, out-of-order writeback
// capture, operand lookup by tag, and in-order single-entry retirement that
// drives the rename-table commit/flush interface and the GPR write.
// Ports:
//   alloc_*            dispatch request and the instruction's static info
//   alloc_ready        a slot is free this cycle
//   allocate_en        allocation actually happens this cycle
//   rob_alloc_*_2rat   tag/dst mapping handed to the register alias table
//   wb_*               writeback of a result (and redirect/exception status)
//   rsX_Paddr/rob_*    operand lookup by tag, with same-cycle writeback bypass
//   commit/rob_commit_* retiring entry, combinational from the head entry
module rob_core
    import rob_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      alloc_req,
    input  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
    input  logic                      alloc_dst_wen,
    input  logic [PC_WIDTH-1:0]       alloc_pc,
    input  logic [2:0]                alloc_sys,
    output logic                      alloc_ready,
    output logic                      allocate_en,
    output logic [TAGW-1:0]           rob_alloc_tag_2rat,
    output logic [GPR_ADDR_WIDTH-1:0] rob_alloc_dst_addr_2rat,
    output logic                      rob_alloc_dst_wen_2rat,

    input  logic                      wb_en,
    input  logic [TAGW-1:0]           wb_tag,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      wb_br_taken,
    input  logic [PC_WIDTH-1:0]       wb_br_target,
    input  logic                      wb_exp,

    input  logic [TAGW-1:0]           rs1_Paddr,
    input  logic [TAGW-1:0]           rs2_Paddr,
    output logic                      rs1_rob_ready,
    output logic                      rs2_rob_ready,
    output logic [DATA_WIDTH-1:0]     rs1_rob_data,
    output logic [DATA_WIDTH-1:0]     rs2_rob_data,

    output logic                      commit_dst_en,
    output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr_2rat,
    output logic [TAGW-1:0]           rob_commit_Paddr,
    output logic [DATA_WIDTH-1:0]     rob_commit_data,
    output logic [PC_WIDTH-1:0]       rob_commit_pc,
    output logic                      rob_commit_br_taken,
    output logic [PC_WIDTH-1:0]       rob_commit_redirect_pc,
    output logic                      rob_commit_exp_en,
    output logic [2:0]                rob_commit_ebreak_ecall_mret
);

    rob_entry_t      entries [ROB_DEPTH];
    rob_entry_t      head_e;
    logic [TAGW:0]   head;
    logic [TAGW:0]   tail;
    logic [TAGW-1:0] head_idx;
    logic [TAGW-1:0] tail_idx;
    logic            full;
    logic            commit_fire;
    logic            flush;
    logic            wb_hit;

    assign head_idx = head[TAGW-1:0];
    assign tail_idx = tail[TAGW-1:0];
    assign head_e   = entries[head_idx];

    assign full        = (head_idx == tail_idx) && (head[TAGW] != tail[TAGW]);
    assign commit_fire = head_e.valid & head_e.done;
    // ebreak retires normally; ecall/mret, exceptions and redirects squash the ROB
    assign flush       = commit_fire & (head_e.br_taken | head_e.exp |
                                        head_e.sys[SYS_ECALL] | head_e.sys[SYS_MRET]);

    // Fullness is taken from the registered pointers, so a slot freed by this
    // cycle's commit only becomes allocatable next cycle.
    assign alloc_ready = !full;
    assign allocate_en = alloc_req & alloc_ready & !flush;

    assign rob_alloc_tag_2rat      = tail_idx;
    assign rob_alloc_dst_addr_2rat = alloc_dst_addr;
    assign rob_alloc_dst_wen_2rat  = alloc_dst_wen;

    assign wb_hit = wb_en & entries[wb_tag].valid & !flush;

    rob_ptr u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (commit_fire & !flush),
        .clr   (flush),
        .ptr   (head)
    );

    rob_ptr u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (allocate_en),
        .clr   (flush),
        .ptr   (tail)
    );

    // Only the valid/done flags are reset; payload fields are qualified by them.
    // The allocated slot can never be the committing head (full blocks
    // allocation, and an empty ROB has nothing to commit).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
        end else if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
            end
        end else begin
            if (wb_hit) begin
                entries[wb_tag].done     <= 1'b1;
                entries[wb_tag].data     <= wb_data;
                entries[wb_tag].br_taken <= wb_br_taken;
                entries[wb_tag].target   <= wb_br_target;
                entries[wb_tag].exp      <= wb_exp;
            end
            if (commit_fire) begin
                entries[head_idx].valid <= 1'b0;
                entries[head_idx].done  <= 1'b0;
            end
            if (allocate_en) begin
                entries[tail_idx] <= '{valid:    1'b1,
                                       done:     1'b0,
                                       dst_wen:  alloc_dst_wen,
                                       dst:      alloc_dst_addr,
                                       data:     '0,
                                       pc:       alloc_pc,
                                       br_taken: 1'b0,
                                       target:   '0,
                                       exp:      1'b0,
                                       sys:      alloc_sys};
            end
        end
    end

    // Operand lookup: a writeback in flight this cycle wins over stored state.
    always_comb begin
        rs1_rob_ready = 1'b0;
        rs1_rob_data  = '0;
        if (wb_en && (wb_tag == rs1_Paddr)) begin
            rs1_rob_ready = 1'b1;
            rs1_rob_data  = wb_data;
        end else if (entries[rs1_Paddr].valid && entries[rs1_Paddr].done) begin
            rs1_rob_ready = 1'b1;
            rs1_rob_data  = entries[rs1_Paddr].data;
        end
    end

    always_comb begin
        rs2_rob_ready = 1'b0;
        rs2_rob_data  = '0;
        if (wb_en && (wb_tag == rs2_Paddr)) begin
            rs2_rob_ready = 1'b1;
            rs2_rob_data  = wb_data;
        end else if (entries[rs2_Paddr].valid && entries[rs2_Paddr].done) begin
            rs2_rob_ready = 1'b1;
            rs2_rob_data  = entries[rs2_Paddr].data;
        end
    end

    always_comb begin
        commit_dst_en                = 1'b0;
        rob_commit_dst_addr_2rat     = '0;
        rob_commit_Paddr             = '0;
        rob_commit_data              = '0;
        rob_commit_pc                = '0;
        rob_commit_br_taken          = 1'b0;
        rob_commit_redirect_pc       = '0;
        rob_commit_exp_en            = 1'b0;
        rob_commit_ebreak_ecall_mret = '0;
        if (commit_fire) begin
            commit_dst_en                = head_e.dst_wen & !head_e.exp;
            rob_commit_dst_addr_2rat     = head_e.dst;
            rob_commit_Paddr             = head_idx;
            rob_commit_data              = head_e.data;
            rob_commit_pc                = head_e.pc;
            rob_commit_br_taken          = head_e.br_taken;
            rob_commit_redirect_pc       = head_e.target;
            rob_commit_exp_en            = head_e.exp;
            rob_commit_ebreak_ecall_mret = head_e.sys;
        end
    end

endmodule
